// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
//   Shared types and constants for the debounce block.
//   - state_e              : debouncer FSM states (ST_LOW / ST_HIGH)
//   - DEFAULT_HOLD_CYCLES  : default number of consecutive low samples that
//                            are required before the output deasserts
//   - hold_cnt_width()     : width of a low-sample counter that can hold
//                            0..hold_cycles
// -----------------------------------------------------------------------------
package debounce_pkg;

   typedef enum logic {
      ST_LOW  = 1'b0,
      ST_HIGH = 1'b1
   } state_e;

   localparam int unsigned DEFAULT_HOLD_CYCLES = 2;

   function automatic int unsigned hold_cnt_width(input int unsigned hold_cycles);
      int unsigned w;
      w = $clog2(hold_cycles + 1);
      return (w == 0) ? 1 : w;
   endfunction

endpackage : debounce_pkg

// File: rtl/debounce_sync2.sv
// -----------------------------------------------------------------------------
// sync2
//   Two-flop synchronizer for a single-bit signal that is asynchronous to clk.
//   Both flops reset to 0.
//   Ports:
//     clk   in  1  destination clock
//     rst_n in  1  asynchronous active-low reset
//     d_i   in  1  asynchronous input
//     q_o   out 1  input synchronized to clk (2 clocks of latency)
// -----------------------------------------------------------------------------
module sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule : sync2

// File: rtl/debounce.sv
// -----------------------------------------------------------------------------
// debounce
//   Turns a bouncing button input into a clean level. The output asserts on
//   the first clock edge that samples the input high. It deasserts only after
//   HOLD_CYCLES consecutive low samples, so shorter low-going bounces are
//   filtered out.
//
//   Parameters:
//     HOLD_CYCLES  consecutive low samples needed to deassert s (>= 1)
//
//   Ports:
//     clk    in  1  system clock; all state updates on the rising edge
//     rst_n  in  1  asynchronous active-low reset
//     b      in  1  raw (bouncing) button input
//     s      out 1  debounced level, driven directly by a flop
//
//   Build option:
//     DEBOUNCE_SYNC_EN  when defined, b passes through a 2-flop synchronizer
//                       (sync2) before the FSM. This adds 2 clocks of
//                       assert and deassert latency. Define it when b is
//                       asynchronous to clk.
// -----------------------------------------------------------------------------
module debounce
   import debounce_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic b,
   output logic s
);

   localparam int unsigned      CW       = hold_cnt_width(HOLD_CYCLES);
   // Count value at which one more low sample completes the hold window.
   localparam logic [CW-1:0]    CNT_LAST = CW'(HOLD_CYCLES - 1);

   logic          b_smp;
   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic          s_q,     s_d;

`ifdef DEBOUNCE_SYNC_EN
   sync2 u_sync2 (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (b),
      .q_o   (b_smp)
   );
`else
   assign b_smp = b;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      s_d     = s_q;
      case (state_q)
         ST_LOW: begin
            // There is no rise filter: the first high sample asserts s.
            cnt_d = '0;
            if (b_smp) begin
               state_d = ST_HIGH;
               s_d     = 1'b1;
            end
         end
         ST_HIGH: begin
            if (b_smp) begin
               cnt_d = '0;
            end else if (cnt_q >= CNT_LAST) begin
               // This is the HOLD_CYCLES-th consecutive low sample, so drop
               // s on this edge. The >= comparison also bounds the counter,
               // which therefore never wraps.
               state_d = ST_LOW;
               s_d     = 1'b0;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = ST_LOW;
            s_d     = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_LOW;
         cnt_q   <= '0;
         s_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         s_q     <= s_d;
      end
   end

   assign s = s_q;

endmodule : debounce

// File: tb/tb_debounce.sv
// -----------------------------------------------------------------------------
// tb_debounce
//   Directed bench for debounce (default build, DEBOUNCE_SYNC_EN undefined).
//   The clock period is 60 time units, with rising edges at 30, 90, 150, ...
//   dut_a uses HOLD_CYCLES=2 and dut_b uses HOLD_CYCLES=4. The two share the
//   clock and the reset. All stimulus times below are absolute.
// -----------------------------------------------------------------------------
module tb_debounce;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic b_a   = 1'b0;
   logic b_b   = 1'b0;
   logic s_a;
   logic s_b;

   int unsigned n_checks   = 0;
   int unsigned n_failures = 0;

   debounce #(.HOLD_CYCLES(2)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .b     (b_a),
      .s     (s_a)
   );

   debounce #(.HOLD_CYCLES(4)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .b     (b_b),
      .s     (s_b)
   );

   always #30 clk = ~clk;

   task automatic check_eq(input string tag, input logic got, input logic exp);
      n_checks++;
      if (got !== exp) begin
         n_failures++;
         $display("FAIL %s at t=%0t: got %b expected %b", tag, $time, got, exp);
      end
   endtask

   task automatic at(input longint t);
      #(t - longint'($time));
   endtask

   initial begin
      // 1. Reset, release it, then keep b low for three edges.
      at(1);    rst_n = 1'b0;              // asynchronous reset, before any edge
      at(5);    check_eq("reset_a", s_a, 1'b0);
                check_eq("reset_b", s_b, 1'b0);
      at(20);   rst_n = 1'b1;
      at(35);   check_eq("low_e30", s_a, 1'b0);
      at(95);   check_eq("low_e90", s_a, 1'b0);
      at(155);  check_eq("low_e150", s_a, 1'b0);

      // 2. b rises 5 units before the edge at 210; s rises on that edge.
      at(205);  b_a = 1'b1;
      at(206);  check_eq("rise_pre", s_a, 1'b0);   // no combinational path
      at(215);  check_eq("rise_post", s_a, 1'b1);

      // 3. Bounces. The edge at 270 samples 0 once, and the edge at 330
      //    samples 1. Glitches at 310..320 fall between edges.
      at(225);  b_a = 1'b0;
      at(240);  b_a = 1'b1;
      at(255);  b_a = 1'b0;
      at(275);  check_eq("bounce_e270", s_a, 1'b1);
      at(280);  b_a = 1'b1;
      at(290);  b_a = 1'b0;
      at(300);  b_a = 1'b1;
      at(310);  b_a = 1'b0;
      at(320);  b_a = 1'b1;
      at(335);  check_eq("bounce_e330", s_a, 1'b1);
      at(395);  check_eq("bounce_e390", s_a, 1'b1);

      // 4. Two low edges (450, 510) drop s at 510. A single low edge does not.
      at(400);  b_a = 1'b0;
      at(455);  check_eq("hold_1st_low", s_a, 1'b1);
      at(505);  check_eq("hold_pre_2nd", s_a, 1'b1);
      at(515);  check_eq("hold_2nd_low", s_a, 1'b0);
      at(520);  b_a = 1'b1;
      at(575);  check_eq("rehigh", s_a, 1'b1);
      at(580);  b_a = 1'b0;
      at(635);  check_eq("single_low", s_a, 1'b1);
      at(640);  b_a = 1'b1;
      at(695);  check_eq("single_low_recov", s_a, 1'b1);

      // 5. Assert reset mid-count, between edges (counter=1 after the edge at 750).
      at(700);  b_a = 1'b0;
      at(755);  check_eq("pre_reset_count", s_a, 1'b1);
      at(760);  rst_n = 1'b0;
      at(761);  check_eq("async_reset", s_a, 1'b0);
      at(780);  rst_n = 1'b1; b_a = 1'b1;
      at(815);  check_eq("post_reset_rise", s_a, 1'b1);
      at(820);  b_a = 1'b0;
      at(875);  check_eq("post_reset_1low", s_a, 1'b1);   // count restarted from 0
      at(935);  check_eq("post_reset_2low", s_a, 1'b0);

      // 6. HOLD_CYCLES=4: a run of 3 lows keeps s high, and a run of 4 drops it.
      at(940);  b_b = 1'b1;
      at(995);  check_eq("h4_rise", s_b, 1'b1);
      at(1000); b_b = 1'b0;                                 // lows at 1050,1110,1170
      at(1175); check_eq("h4_3low", s_b, 1'b1);
      at(1180); b_b = 1'b1;
      at(1235); check_eq("h4_recov", s_b, 1'b1);
      at(1240); b_b = 1'b0;                                 // lows at 1290..1470
      at(1415); check_eq("h4_3low_again", s_b, 1'b1);
      at(1465); check_eq("h4_pre_4th", s_b, 1'b1);
      at(1475); check_eq("h4_4th_low", s_b, 1'b0);
      at(1535); check_eq("h4_stay_low", s_b, 1'b0);
      at(1540); b_b = 1'b1;
      at(1595); check_eq("h4_rerise", s_b, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
      $finish;
   end

endmodule : tb_debounce
